// File: rtl/config_shift_sequencer.sv
// config_shift_sequencer
//   Runs one complete load of the chip configuration shift register. 32-bit words from
//   the AXI side are serialised LSB-first onto ConfigIn under a divided ConfigClk. After
//   the last bit, ConfigLoad is pulsed for one ConfigClk period and done pulses once.
//   A separate chip reset sequence holds Reset_not low for RST_PERIODS ConfigClk periods.
//
//   Optional feature macro: CONFIG_READBACK_EN
//     defined   : ConfigOut is sampled on the last high cycle of each bit. Bits are packed
//                 LSB-first into 32-bit words and presented on rd_data/rd_valid.
//     undefined : ConfigOut is ignored and rd_valid/rd_data are tied to zero.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET : clock, synchronous active-high reset
//   start, abort, chip_rst_req : control pulses (abort wins over everything)
//   superpix_sel               : captured on an accepted start, drives SuperpixSel
//   wr_data/wr_valid/wr_ready  : config word stream in (bit0 shifted first)
//   rd_data/rd_valid/rd_ready  : readback word stream out
//   busy, done, bit_cnt        : status
//   SuperpixSel, ConfigClk, Reset_not, ConfigIn, ConfigLoad, ConfigOut : chip pins
module config_shift_sequencer #(
    parameter int unsigned CONFIG_REG_WIDTH = 5164,
    parameter int unsigned CLK_DIVIDER      = 100,
    parameter int unsigned RST_PERIODS      = 4
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        start,
    input  logic        abort,
    input  logic        chip_rst_req,
    input  logic        superpix_sel,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic [12:0] bit_cnt,
    output logic        SuperpixSel,
    output logic        ConfigClk,
    output logic        Reset_not,
    output logic        ConfigIn,
    output logic        ConfigLoad,
    input  logic        ConfigOut
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned BCNT_W  = 13;
    localparam int unsigned HALF    = CLK_DIVIDER / 2;
    localparam int unsigned PH_W    = $clog2(CLK_DIVIDER);
    localparam int unsigned RST_CYC = RST_PERIODS * CLK_DIVIDER;
    localparam int unsigned TMR_MAX = (RST_CYC > CLK_DIVIDER) ? RST_CYC : CLK_DIVIDER;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [PH_W-1:0]   PH_HALF       = PH_W'(HALF);
    localparam logic [PH_W-1:0]   PH_LAST       = PH_W'(CLK_DIVIDER - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD_LAST = TMR_W'(CLK_DIVIDER - 1);
    localparam logic [TMR_W-1:0]  TMR_RST_LAST  = TMR_W'(RST_CYC - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT      = BCNT_W'(CONFIG_REG_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(WORD_W - 1);

`ifdef CONFIG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    // S_DRAIN waits for the final readback word to be taken before LOAD.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_LOAD,
        S_DONE,
        S_CHIPRST
    } state_t;

    state_t              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                popped_all_q, popped_all_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                spx_q, spx_d;
    logic                cfg_in_q, cfg_in_d;
    logic                cfg_clk_q, cfg_clk_d;
    logic                cfg_load_q, cfg_load_d;
    logic                reset_not_q, reset_not_d;
    logic                wr_ready_q, wr_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                shift_sample;
    logic                rb_stall;
    logic                rb_drained;

    // Next-state, phase sequencing and registered-output decode.
    always_comb begin
        state_d      = state_q;
        ph_d         = ph_q;
        tmr_d        = tmr_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        idx_d        = idx_q;
        popped_all_d = popped_all_q;
        bit_cnt_d    = bit_cnt_q;
        spx_d        = spx_q;
        cfg_in_d     = cfg_in_q;
        shift_sample = 1'b0;

        if (wr_valid && wr_ready_q) begin
            buf_d      = wr_data;
            buf_full_d = 1'b1;
            idx_d      = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (chip_rst_req) begin
                    state_d = S_CHIPRST;
                    tmr_d   = '0;
                end else if (start) begin
                    state_d      = S_SHIFT;
                    ph_d         = '0;
                    bit_cnt_d    = '0;
                    spx_d        = superpix_sel;
                    buf_full_d   = 1'b0;
                    popped_all_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (ph_q == '0) begin
                    // Low-phase start: wait here on empty buffer or blocked readback.
                    if (buf_full_q && !rb_stall) begin
                        cfg_in_d = buf_q[idx_q];
                        idx_d    = idx_q + 1'b1;
                        if (idx_q == IDX_LAST || bit_cnt_q == LAST_BIT) begin
                            buf_full_d = 1'b0;
                        end
                        if (bit_cnt_q == LAST_BIT) begin
                            popped_all_d = 1'b1;
                        end
                        ph_d = ph_q + 1'b1;
                    end
                end else if (ph_q == PH_LAST) begin
                    shift_sample = 1'b1;
                    bit_cnt_d    = bit_cnt_q + 1'b1;
                    ph_d         = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = READBACK ? S_DRAIN : S_LOAD;
                        tmr_d   = '0;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (rb_drained) begin
                    state_d = S_LOAD;
                    tmr_d   = '0;
                end
            end
            S_LOAD: begin
                if (tmr_q == TMR_LOAD_LAST) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_CHIPRST: begin
                if (tmr_q == TMR_RST_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            ph_d         = '0;
            tmr_d        = '0;
            buf_full_d   = 1'b0;
            popped_all_d = 1'b0;
        end

        if (state_d != S_SHIFT) begin
            cfg_in_d = 1'b0;
        end

        // Outputs follow the next state so the pins line up with the state register.
        cfg_clk_d   = (state_d == S_SHIFT) && (ph_d >= PH_HALF);
        cfg_load_d  = (state_d == S_LOAD);
        reset_not_d = (state_d != S_CHIPRST);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        wr_ready_d  = (state_d == S_SHIFT) && !buf_full_d && !popped_all_d;
    end

    // State and output registers.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q      <= S_IDLE;
            ph_q         <= '0;
            tmr_q        <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            idx_q        <= '0;
            popped_all_q <= 1'b0;
            bit_cnt_q    <= '0;
            spx_q        <= 1'b0;
            cfg_in_q     <= 1'b0;
            cfg_clk_q    <= 1'b0;
            cfg_load_q   <= 1'b0;
            reset_not_q  <= 1'b1;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            tmr_q        <= tmr_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            idx_q        <= idx_d;
            popped_all_q <= popped_all_d;
            bit_cnt_q    <= bit_cnt_d;
            spx_q        <= spx_d;
            cfg_in_q     <= cfg_in_d;
            cfg_clk_q    <= cfg_clk_d;
            cfg_load_q   <= cfg_load_d;
            reset_not_q  <= reset_not_d;
            wr_ready_q   <= wr_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef CONFIG_READBACK_EN
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [5:0]        acc_cnt_q, acc_cnt_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rb_can_load;

    // Readback accumulator: a full word, or the partial tail in S_DRAIN, moves to rd_data
    // whenever the output slot is free or being emptied this cycle.
    always_comb begin
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        rd_data_d   = rd_data_q;
        rb_can_load = !rd_valid_q || rd_ready;
        rd_valid_d  = rd_valid_q && !rd_ready;

        if (rb_can_load && ((acc_cnt_q == 6'd32) ||
                            (state_q == S_DRAIN && acc_cnt_q != 6'd0))) begin
            rd_data_d  = acc_q;
            rd_valid_d = 1'b1;
            acc_d      = '0;
            acc_cnt_d  = '0;
        end

        if (shift_sample) begin
            acc_d[acc_cnt_q[4:0]] = ConfigOut;
            acc_cnt_d             = acc_cnt_q + 6'd1;
        end

        if (abort) begin
            acc_d      = '0;
            acc_cnt_d  = '0;
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rb_stall   = rd_valid_q && (acc_cnt_q == 6'd32);
    assign rb_drained = (acc_cnt_q == 6'd0) && rb_can_load;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
`else
    logic unused_readback;
    assign unused_readback = ^{ConfigOut, rd_ready, shift_sample};
    assign rb_stall        = 1'b0;
    assign rb_drained      = 1'b1;
    assign rd_data         = '0;
    assign rd_valid        = 1'b0;
`endif

    assign wr_ready    = wr_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign bit_cnt     = bit_cnt_q;
    assign SuperpixSel = spx_q;
    assign ConfigClk   = cfg_clk_q;
    assign Reset_not   = reset_not_q;
    assign ConfigIn    = cfg_in_q;
    assign ConfigLoad  = cfg_load_q;

endmodule

// File: tb/tb_config_shift_sequencer.sv
// Directed bench for config_shift_sequencer (40-bit register, divider 4).
module tb_config_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        chip_rst_req = 1'b0;
    logic        superpix_sel = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [12:0] bit_cnt;
    logic        SuperpixSel;
    logic        ConfigClk;
    logic        Reset_not;
    logic        ConfigIn;
    logic        ConfigLoad;
    logic        ConfigOut = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    config_shift_sequencer #(
        .CONFIG_REG_WIDTH(40),
        .CLK_DIVIDER     (4),
        .RST_PERIODS     (4)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .start       (start),
        .abort       (abort),
        .chip_rst_req(chip_rst_req),
        .superpix_sel(superpix_sel),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .done        (done),
        .bit_cnt     (bit_cnt),
        .SuperpixSel (SuperpixSel),
        .ConfigClk   (ConfigClk),
        .Reset_not   (Reset_not),
        .ConfigIn    (ConfigIn),
        .ConfigLoad  (ConfigLoad),
        .ConfigOut   (ConfigOut)
    );

    always #5 clk = ~clk;

    // Pin monitor: counts ConfigClk rises, ConfigLoad and done cycles, records ConfigIn at
    // each rise, and loops ConfigIn back onto ConfigOut delayed by 32 bits.
    int unsigned rise_cnt = 0;
    int unsigned load_cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned load_bit = 0;
    logic        cap_bits [0:511];
    logic [63:0] cur_bits = '0;
    logic        prev_cclk = 1'b0;

    always @(negedge clk) begin
        if (!busy) load_bit = 0;
        if (ConfigClk && !prev_cclk) begin
            cap_bits[rise_cnt % 512] = ConfigIn;
            rise_cnt = rise_cnt + 1;
            ConfigOut = (load_bit >= 32) ? cur_bits[(load_bit - 32) % 64] : 1'b0;
            cur_bits[load_bit % 64] = ConfigIn;
            load_bit = load_bit + 1;
        end
        if (ConfigLoad) load_cyc = load_cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        prev_cclk = ConfigClk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the falling edge so the monitor has already updated.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] captured(input int unsigned base, input int unsigned n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) v[i] = cap_bits[(base + i) % 512];
        end
        return v;
    endfunction

    task automatic pulse_start(input logic spx);
        tick();
        start        = 1'b1;
        superpix_sel = spx;
        tick();
        start        = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        tick();
        wr_data  = w;
        wr_valid = 1'b1;
        while (!wr_ready && t < 500) begin
            tick();
            t++;
        end
        check("wr_accept", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rises(input int unsigned base, input int unsigned n);
        int t;
        t = 0;
        while ((rise_cnt - base) < n && t < 1000) begin
            tick();
            t++;
        end
        check("rise_wait", 64'(rise_cnt - base), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned rb;
        int unsigned lb;
        int unsigned db;
        int          clk_hi;
        int          in_chg;
        int          low_n;
        int          busy_n;
        logic        held_in;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_cclk",    64'(ConfigClk),   64'd0);
        check("rst_resetn",  64'(Reset_not),   64'd1);
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_wrready", 64'(wr_ready),    64'd0);
        check("rst_bitcnt",  64'(bit_cnt),     64'd0);
        check("rst_load",    64'(ConfigLoad),  64'd0);
        check("rst_rdvalid", 64'(rd_valid),    64'd0);

        // Basic load
        rb = rise_cnt; lb = load_cyc; db = done_cnt;
        pulse_start(1'b1);
        check("basic_busy", 64'(busy), 64'd1);
        send_word(32'hA5A5A5A5);
        send_word(32'h000000C3);
        wait_idle("basic_idle");
        check("basic_rises",  64'(rise_cnt - rb), 64'd40);
        check("basic_bits",   captured(rb, 40), 64'h000000C3A5A5A5A5);
        check("basic_loadcy", 64'(load_cyc - lb), 64'd4);
        check("basic_done",   64'(done_cnt - db), 64'd1);
        check("basic_bitcnt", 64'(bit_cnt), 64'd40);
        check("basic_spx",    64'(SuperpixSel), 64'd1);
        check("basic_cin",    64'(ConfigIn), 64'd0);
`ifndef CONFIG_READBACK_EN
        check("basic_rdvalid", 64'(rd_valid), 64'd0);
        check("basic_rddata",  64'(rd_data),  64'd0);
`endif

        // Underflow: second word withheld
        rb = rise_cnt; db = done_cnt;
        pulse_start(1'b0);
        check("uf_bitcnt_clr", 64'(bit_cnt), 64'd0);
        send_word(32'h92345678);
        while (!wr_ready && (rise_cnt - rb) < 40) tick();
        repeat (4) tick();
        clk_hi = 0; in_chg = 0; held_in = ConfigIn;
        for (int i = 0; i < 20; i++) begin
            if (ConfigClk) clk_hi++;
            if (ConfigIn !== held_in) in_chg++;
            tick();
        end
        check("uf_clk_low",   64'(clk_hi), 64'd0);
        check("uf_in_stable", 64'(in_chg), 64'd0);
        check("uf_held_bit",  64'(held_in), 64'd1);
        check("uf_rises",     64'(rise_cnt - rb), 64'd32);
        send_word(32'h0000009F);
        wait_idle("uf_idle");
        check("uf_bits", captured(rb, 40), 64'h0000009F92345678);
        check("uf_done", 64'(done_cnt - db), 64'd1);

        // Abort at bit 17
        rb = rise_cnt; lb = load_cyc; db = done_cnt;
        pulse_start(1'b0);
        send_word(32'hFFFFFFFF);
        wait_rises(rb, 17);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_cclk", 64'(ConfigClk),  64'd0);
        check("ab_load", 64'(ConfigLoad), 64'd0);
        check("ab_cin",  64'(ConfigIn),   64'd0);
        check("ab_busy", 64'(busy),       64'd0);
        repeat (10) tick();
        check("ab_nodone",  64'(done_cnt - db), 64'd0);
        check("ab_noload",  64'(load_cyc - lb), 64'd0);
        check("ab_rises",   64'(rise_cnt - rb), 64'd17);

        // Clean load after abort
        rb = rise_cnt; db = done_cnt;
        pulse_start(1'b0);
        send_word(32'h0F0F0F0F);
        send_word(32'h00000055);
        wait_idle("ab2_idle");
        check("ab2_rises",  64'(rise_cnt - rb), 64'd40);
        check("ab2_bits",   captured(rb, 40), 64'h000000550F0F0F0F);
        check("ab2_done",   64'(done_cnt - db), 64'd1);
        check("ab2_bitcnt", 64'(bit_cnt), 64'd40);

        // chip_rst_req together with start
        rb = rise_cnt;
        tick();
        start = 1'b1;
        chip_rst_req = 1'b1;
        tick();
        start = 1'b0;
        chip_rst_req = 1'b0;
        low_n = 0; busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (!Reset_not) begin
                low_n++;
                if (busy) busy_n++;
            end
            tick();
        end
        check("crst_low",    64'(low_n),  64'd16);
        check("crst_busy",   64'(busy_n), 64'd16);
        check("crst_rises",  64'(rise_cnt - rb), 64'd0);
        check("crst_idle",   64'(busy), 64'd0);
        check("crst_bitcnt", 64'(bit_cnt), 64'd40);

`ifdef CONFIG_READBACK_EN
        // Readback with loopback ConfigOut
        rd_ready = 1'b0;
        rb = rise_cnt; lb = load_cyc; db = done_cnt;
        pulse_start(1'b0);
        send_word(32'hA5A5A5A5);
        send_word(32'h000000C3);
        wait_rises(rb, 40);
        repeat (20) tick();
        check("rb_hold_load", 64'(load_cyc - lb), 64'd0);
        check("rb_busy",      64'(busy), 64'd1);
        check("rb_valid0",    64'(rd_valid), 64'd1);
        check("rb_word0",     64'(rd_data), 64'd0);
        rd_ready = 1'b1;
        tick();
        check("rb_valid1", 64'(rd_valid), 64'd1);
        check("rb_word1",  64'(rd_data), 64'h000000A5);
        tick();
        rd_ready = 1'b0;
        wait_idle("rb_idle");
        check("rb_loadcy",   64'(load_cyc - lb), 64'd4);
        check("rb_done",     64'(done_cnt - db), 64'd1);
        check("rb_valid_end", 64'(rd_valid), 64'd0);
        rd_ready = 1'b1;
`endif

        // Synchronous reset mid-SHIFT
        rb = rise_cnt;
        pulse_start(1'b1);
        send_word(32'hFFFFFFFF);
        wait_rises(rb, 5);
        check("mr_cin_pre", 64'(ConfigIn), 64'd1);
        rst = 1'b1;
        tick();
        check("mr_cclk",    64'(ConfigClk),   64'd0);
        check("mr_cin",     64'(ConfigIn),    64'd0);
        check("mr_busy",    64'(busy),        64'd0);
        check("mr_bitcnt",  64'(bit_cnt),     64'd0);
        check("mr_spx",     64'(SuperpixSel), 64'd0);
        check("mr_wrready", 64'(wr_ready),    64'd0);
        check("mr_resetn",  64'(Reset_not),   64'd1);
        check("mr_load",    64'(ConfigLoad),  64'd0);
        rst = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
